cim_cmd_seq: RTL and testbench
==============================

CIM_CMD_SEQ -- requirements
Module: cim_cmd_seq

Interface
REQ-001 SHALL have parameter MAC_LAT, default 2: cycles op_code 00 is held before the MAC result is captured, legal range 1..15.
REQ-002 SHALL have parameter READ_LAT, default 1: cycles op_code 10 is held before the read result is captured, legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req_valid input 1 and req_ready output 1: host command handshake.
REQ-006 SHALL have port req_op  input  2  command: 00 MAC, 01 WRITE, 10 READ, 11 NOP.
REQ-007 SHALL have ports req_bank input 4 (start bank), req_col input 3 (column), req_cnt input 4 (burst length minus 1).
REQ-008 SHALL have ports req_wdata input 16 (bank data / weights) and req_act input 16 (MAC activations).
REQ-009 SHALL have port arr_result  input  16  result bus returned by the array adder tree.
REQ-010 SHALL have outputs op_code 2, addr_bank 4, addr_col 3, data_bank 16 and data_in 16 driving the array controller; all are registered.
REQ-011 SHALL have ports rsp_valid output 1, rsp_ready input 1 and rsp_data output 16: result handshake.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-014 SHALL assert req_ready in IDLE only; a request is accepted when req_valid and req_ready are both high, and all req_* fields are latched on that edge.
REQ-015 SHALL discard an accepted NOP and stay in IDLE.
REQ-016 SHALL drive the array outputs for any other accepted command starting the cycle after acceptance (latency 1).
REQ-017 For WRITE, SHALL stay in ISSUE for req_cnt+1 cycles, driving op_code=01, data_bank=latched wdata and addr_bank=start+i modulo 16 (15 wraps to 0), then return to IDLE with no response.
REQ-018 For READ, SHALL drive op_code=10 and addr_col=latched col for 1 ISSUE cycle plus READ_LAT WAIT cycles.
REQ-019 For MAC, SHALL drive op_code=00, data_bank=wdata and data_in=act for 1 ISSUE cycle plus MAC_LAT WAIT cycles.
REQ-020 SHALL capture arr_result into rsp_data on the last WAIT cycle, then enter RESP.
REQ-021 In RESP, SHALL drive op_code=11, assert rsp_valid and hold rsp_data stable until rsp_ready is sampled high, then return to IDLE.
REQ-022 If rsp_ready is already high on entry to RESP, SHALL spend exactly 1 cycle in RESP.
REQ-023 In IDLE, SHALL drive op_code=11 with data_bank and data_in equal to 0.
REQ-024 SHALL use a 4-bit internal WAIT counter and SHALL NOT wrap it within one command.
REQ-025 SHALL ignore req_valid while not in IDLE; no queueing.

Reset
REQ-026 SHALL, while rst is high, force state=IDLE, op_code=11, addr_bank=0, addr_col=0, data_bank=0, data_in=0, rsp_data=0, rsp_valid=0, busy=0 and req_ready=0.
REQ-027 SHALL set req_ready=1 in the first cycle after rst deasserts.
REQ-028 SHALL abort any command in progress when rst is asserted mid-command (burst, WAIT or RESP), drop any pending response, and emit no further array operations.

Configuration
REQ-029 With macro CMD_SEQ_BURST_EN defined, SHALL implement WRITE bursts as in REQ-017.
REQ-030 Without CMD_SEQ_BURST_EN, SHALL ignore req_cnt, issue every WRITE as a single ISSUE cycle, and leave all other behaviour unchanged.

Verification
REQ-031 Reset: rst high for 3 cycles, then low -> op_code=11, rsp_valid=0, busy=0 throughout reset, and req_ready=1 in the first cycle after release.
REQ-032 Burst wrap: WRITE bank=14, cnt=3, wdata=16'hA5A5 with CMD_SEQ_BURST_EN -> 4 cycles of op_code=01 with addr_bank 14,15,0,1, then IDLE; without the macro -> 1 cycle at bank 14.
REQ-033 READ: col=5, READ_LAT=1, arr_result=16'h0123 -> op_code=10 and addr_col=5 for 2 cycles, then rsp_valid=1 with rsp_data=16'h0123.
REQ-034 MAC backpressure: act=16'hFFFF, wdata=16'h00FF, MAC_LAT=2, rsp_ready low for 4 cycles -> op_code=00 for 3 cycles, then rsp_valid and rsp_data held stable for 4 cycles; IDLE the cycle after rsp_ready rises.
REQ-035 Abort and NOP: rst during WAIT of a MAC -> no rsp_valid ever; NOP request -> accepted, busy stays 0, op_code stays 11.
REQ-036 Ignored request: req_valid held high during a READ -> exactly one command executed; the next command is accepted only on return to IDLE.

Source files
------------

// File: rtl/cim_cmd_seq_if.sv
// rtl/cim_cmd_seq_if.sv - host, array and response signals of the CIM command sequencer
// master: host/array side driving requests; slave: the sequencer itself.
interface cim_cmd_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_bank;
  logic [2:0]  req_col;
  logic [3:0]  req_cnt;
  logic [15:0] req_wdata;
  logic [15:0] req_act;
  logic [15:0] arr_result;
  logic [1:0]  op_code;
  logic [3:0]  addr_bank;
  logic [2:0]  addr_col;
  logic [15:0] data_bank;
  logic [15:0] data_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        busy;

  modport master (
    output req_valid, req_op, req_bank, req_col, req_cnt, req_wdata, req_act,
           arr_result, rsp_ready,
    input  req_ready, op_code, addr_bank, addr_col, data_bank, data_in,
           rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_bank, req_col, req_cnt, req_wdata, req_act,
           arr_result, rsp_ready,
    output req_ready, op_code, addr_bank, addr_col, data_bank, data_in,
           rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/cim_cmd_seq.sv
// rtl/cim_cmd_seq.sv - compute-in-memory command sequencer (IDLE/ISSUE/WAIT/RESP)
// Optional feature: define CMD_SEQ_BURST_EN for multi-bank WRITE bursts driven by req_cnt.
module cim_cmd_seq #(
  parameter int MAC_LAT  = 2,
  parameter int READ_LAT = 1
) (
  input logic            clk,
  input logic            rst,
  cim_cmd_seq_if.slave   bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] OP_MAC   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  localparam logic [3:0] MAC_WAIT  = 4'(MAC_LAT - 1);
  localparam logic [3:0] READ_WAIT = 4'(READ_LAT - 1);

  logic [1:0]  state;
  logic [1:0]  cur_op;
  logic [3:0]  burst_left;
  logic [3:0]  wait_cnt;
  logic [1:0]  op_code_q;
  logic [3:0]  addr_bank_q;
  logic [2:0]  addr_col_q;
  logic [15:0] data_bank_q;
  logic [15:0] data_in_q;
  logic [15:0] rsp_data_q;

  // Status is gated by rst so it reads idle for the whole reset window.
  assign bus.req_ready = (state == S_IDLE) && !rst;
  assign bus.busy      = (state != S_IDLE) && !rst;
  assign bus.rsp_valid = (state == S_RESP) && !rst;
  assign bus.op_code   = op_code_q;
  assign bus.addr_bank = addr_bank_q;
  assign bus.addr_col  = addr_col_q;
  assign bus.data_bank = data_bank_q;
  assign bus.data_in   = data_in_q;
  assign bus.rsp_data  = rsp_data_q;

`ifndef CMD_SEQ_BURST_EN
  logic unused_req_cnt;
  assign unused_req_cnt = ^bus.req_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cur_op      <= OP_NOP;
      burst_left  <= 4'd0;
      wait_cnt    <= 4'd0;
      op_code_q   <= OP_NOP;
      addr_bank_q <= 4'd0;
      addr_col_q  <= 3'd0;
      data_bank_q <= 16'd0;
      data_in_q   <= 16'd0;
      rsp_data_q  <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_op != OP_NOP) begin
            state       <= S_ISSUE;
            cur_op      <= bus.req_op;
            op_code_q   <= bus.req_op;
            addr_bank_q <= bus.req_bank;
            addr_col_q  <= bus.req_col;
            data_bank_q <= (bus.req_op == OP_READ) ? 16'd0 : bus.req_wdata;
            data_in_q   <= (bus.req_op == OP_MAC) ? bus.req_act : 16'd0;
            wait_cnt    <= (bus.req_op == OP_MAC) ? MAC_WAIT : READ_WAIT;
`ifdef CMD_SEQ_BURST_EN
            burst_left  <= bus.req_cnt;
`else
            burst_left  <= 4'd0;
`endif
          end
        end
        S_ISSUE: begin
          if (cur_op == OP_WRITE) begin
            if (burst_left == 4'd0) begin
              state       <= S_IDLE;
              op_code_q   <= OP_NOP;
              data_bank_q <= 16'd0;
              data_in_q   <= 16'd0;
            end else begin
              // 4-bit add wraps bank 15 back to 0.
              burst_left  <= burst_left - 4'd1;
              addr_bank_q <= addr_bank_q + 4'd1;
            end
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            rsp_data_q  <= bus.arr_result;
            state       <= S_RESP;
            op_code_q   <= OP_NOP;
            data_bank_q <= 16'd0;
            data_in_q   <= 16'd0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cim_cmd_seq.sv
// tb/tb_cim_cmd_seq.sv - directed self-checking bench for cim_cmd_seq
// Burst expectations follow CMD_SEQ_BURST_EN when the bench is built with it.
module tb_cim_cmd_seq;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  cim_cmd_seq_if bus ();

  cim_cmd_seq #(.MAC_LAT(2), .READ_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [1:0] op, input logic [3:0] bank,
                         input logic [2:0] col, input logic [3:0] cnt,
                         input logic [15:0] wdata, input logic [15:0] act);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_bank  = bank;
    bus.req_col   = col;
    bus.req_cnt   = cnt;
    bus.req_wdata = wdata;
    bus.req_act   = act;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    set_req(1'b0, 2'b11, 4'd0, 3'd0, 4'd0, 16'd0, 16'd0);
    bus.arr_result = 16'd0;
    bus.rsp_ready  = 1'b1;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_op_code", 32'(bus.op_code), 32'h3);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_req_ready", 32'(bus.req_ready), 32'h0);
      check("rst_data_bank", 32'(bus.data_bank), 32'h0);
      check("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
    end
    rst = 1'b0;
    tick();
    check("release_req_ready", 32'(bus.req_ready), 32'h1);
    check("release_op_code", 32'(bus.op_code), 32'h3);

    // WRITE burst wrapping through bank 15
    set_req(1'b1, 2'b01, 4'd14, 3'd2, 4'd3, 16'hA5A5, 16'h1234);
    check("wr_pre_op", 32'(bus.op_code), 32'h3);
    tick();
    bus.req_valid = 1'b0;
    check("wr_op0", 32'(bus.op_code), 32'h1);
    check("wr_bank0", 32'(bus.addr_bank), 32'd14);
    check("wr_data0", 32'(bus.data_bank), 32'hA5A5);
    check("wr_busy", 32'(bus.busy), 32'h1);
    check("wr_ready", 32'(bus.req_ready), 32'h0);
`ifdef CMD_SEQ_BURST_EN
    tick();
    check("wr_op1", 32'(bus.op_code), 32'h1);
    check("wr_bank1", 32'(bus.addr_bank), 32'd15);
    tick();
    check("wr_op2", 32'(bus.op_code), 32'h1);
    check("wr_bank2", 32'(bus.addr_bank), 32'd0);
    tick();
    check("wr_op3", 32'(bus.op_code), 32'h1);
    check("wr_bank3", 32'(bus.addr_bank), 32'd1);
`endif
    tick();
    check("wr_end_op", 32'(bus.op_code), 32'h3);
    check("wr_end_busy", 32'(bus.busy), 32'h0);
    check("wr_end_data", 32'(bus.data_bank), 32'h0);
    check("wr_no_rsp", 32'(bus.rsp_valid), 32'h0);

    // READ with req_valid left high throughout
    bus.arr_result = 16'h0123;
    set_req(1'b1, 2'b10, 4'd3, 3'd5, 4'd0, 16'h0, 16'h0);
    tick();
    check("rd_op0", 32'(bus.op_code), 32'h2);
    check("rd_col0", 32'(bus.addr_col), 32'd5);
    check("rd_ready0", 32'(bus.req_ready), 32'h0);
    tick();
    check("rd_op1", 32'(bus.op_code), 32'h2);
    check("rd_col1", 32'(bus.addr_col), 32'd5);
    tick();
    check("rd_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("rd_rsp_data", 32'(bus.rsp_data), 32'h0123);
    check("rd_resp_op", 32'(bus.op_code), 32'h3);
    tick();
    check("rd_idle_valid", 32'(bus.rsp_valid), 32'h0);
    check("rd_idle_op", 32'(bus.op_code), 32'h3);
    check("rd_idle_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 1'b0;
    check("rd2_accept_op", 32'(bus.op_code), 32'h2);
    tick();
    tick();
    check("rd2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    tick();
    check("rd2_idle", 32'(bus.busy), 32'h0);

    // MAC with response backpressure
    bus.rsp_ready  = 1'b0;
    bus.arr_result = 16'hBEEF;
    set_req(1'b1, 2'b00, 4'd7, 3'd1, 4'd0, 16'h00FF, 16'hFFFF);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mac_op", 32'(bus.op_code), 32'h0);
      check("mac_wdata", 32'(bus.data_bank), 32'h00FF);
      check("mac_act", 32'(bus.data_in), 32'hFFFF);
      tick();
    end
    bus.arr_result = 16'h1111;
    for (int i = 0; i < 4; i++) begin
      check("mac_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("mac_rsp_data", 32'(bus.rsp_data), 32'hBEEF);
      check("mac_resp_op", 32'(bus.op_code), 32'h3);
      tick();
    end
    bus.rsp_ready = 1'b1;
    check("mac_rsp_hold", 32'(bus.rsp_valid), 32'h1);
    tick();
    check("mac_idle_valid", 32'(bus.rsp_valid), 32'h0);
    check("mac_idle_busy", 32'(bus.busy), 32'h0);

    // Reset during a MAC WAIT drops the response
    set_req(1'b1, 2'b00, 4'd2, 3'd0, 4'd0, 16'h0F0F, 16'h00AA);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("abort_in_wait", 32'(bus.op_code), 32'h0);
    rst = 1'b1;
    tick();
    check("abort_op", 32'(bus.op_code), 32'h3);
    check("abort_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_no_rsp", 32'(bus.rsp_valid), 32'h0);
      check("abort_no_op", 32'(bus.op_code), 32'h3);
    end

    // NOP is accepted and discarded
    set_req(1'b1, 2'b11, 4'd9, 3'd4, 4'd2, 16'hDEAD, 16'hBEEF);
    check("nop_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 1'b0;
    check("nop_busy", 32'(bus.busy), 32'h0);
    check("nop_op", 32'(bus.op_code), 32'h3);
    check("nop_data", 32'(bus.data_bank), 32'h0);
    tick();
    check("nop_busy2", 32'(bus.busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
